// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling window feeder and the pool stage it drives.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pool_pkg;

    // Default geometry. Instantiations may override these through module parameters.
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_WINDOW_SIZE = 4;
    localparam int DEF_IMG_W       = 16;
    localparam int DEF_IMG_H       = 16;

    // One feature-map pixel, and one full window in the same layout as pool_input.
    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [DEF_WINDOW_SIZE*DEF_WINDOW_SIZE-1:0] window_t;

    // Width of an index that counts 0..n-1. A one-entry range still gets one bit
    // so that no vector collapses to zero width.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_COL_W   = idx_w(DEF_IMG_W);
    localparam int DEF_ROW_W   = idx_w(DEF_IMG_H);
    localparam int DEF_WIN_X_W = idx_w(DEF_IMG_W / DEF_WINDOW_SIZE);
    localparam int DEF_WIN_Y_W = idx_w(DEF_IMG_H / DEF_WINDOW_SIZE);

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer of WS rows x IMG_W pixels; one write port, one window-band read port.
// Latency: write lands on the clock edge; the band read is combinational.
// Backpressure: none here; the parent only writes pixels it has accepted.
//
// Ports:
//   i_clk        clock
//   i_wr_en      write strobe
//   i_wr_row     slot row (image row modulo WS)
//   i_wr_col     image column
//   i_wr_dat     pixel to store
//   i_rd_band    window column index; selects columns band*WS .. band*WS+WS-1
//   o_rd_window  WS x WS pixels of that band, element r*WS+c = slot[r][band*WS+c]
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int WS    = DEF_WINDOW_SIZE,
    parameter int DW    = DEF_DATA_WIDTH,
    parameter int IMG_W = DEF_IMG_W
) (
    input  logic                            i_clk,
    input  logic                            i_wr_en,
    input  logic [idx_w(WS)-1:0]            i_wr_row,
    input  logic [idx_w(IMG_W)-1:0]         i_wr_col,
    input  logic [DW-1:0]                   i_wr_dat,
    input  logic [idx_w(IMG_W/WS)-1:0]      i_rd_band,
    output logic [WS*WS*DW-1:0]             o_rd_window
);

    localparam int COL_W = idx_w(IMG_W);

    // Contents are meaningless until written, so the array carries no reset.
    logic [DW-1:0] r_mem [WS][IMG_W];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row][i_wr_col] <= i_wr_dat;
        end
    end

    for (genvar r = 0; r < WS; r++) begin : g_row
        for (genvar c = 0; c < WS; c++) begin : g_col
            logic [COL_W-1:0] w_idx;
            assign w_idx = COL_W'(i_rd_band) * COL_W'(WS) + COL_W'(c);
            assign o_rd_window[(r*WS+c)*DW +: DW] = r_mem[r][w_idx];
        end
    end

endmodule

// File: rtl/pool_window_buffer.sv
// Buffers WS raster rows and emits each non-overlapping WS x WS window as one vector.
// Latency: window valid 1 cycle after the pixel that completes it is accepted.
// Backpressure: single-entry output; in_ready = !out_valid | out_ready, forced low by clear.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous frame restart (counters to 0, held window dropped)
//   in_valid / in_ready / in_data        pixel stream in raster order
//   out_valid / out_ready / out_window   window, element r*WS+c
//   out_win_x / out_win_y                window column / row index
//   out_last                             last window of the frame
module pool_window_buffer
    import pool_pkg::*;
#(
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0] out_window,
    output logic [$clog2(IMG_W/WINDOW_SIZE)-1:0]        out_win_x,
    output logic [$clog2(IMG_H/WINDOW_SIZE)-1:0]        out_win_y,
    output logic                                        out_last
);

    localparam int WS    = WINDOW_SIZE;
    localparam int N_WX  = IMG_W / WS;
    localparam int N_WY  = IMG_H / WS;
    localparam int SUB_W = idx_w(WS);
    localparam int COL_W = idx_w(IMG_W);
    localparam int WX_W  = $clog2(N_WX);
    localparam int WY_W  = $clog2(N_WY);
    localparam int WIN_W = WS * WS * DATA_WIDTH;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(WS - 1);
    localparam logic [WX_W-1:0]  WX_LAST  = WX_W'(N_WX - 1);
    localparam logic [WY_W-1:0]  WY_LAST  = WY_W'(N_WY - 1);

    // Geometry guards, evaluated at elaboration.
    if (WS < 2) begin : g_bad_ws
        $fatal(1, "pool_window_buffer: WINDOW_SIZE must be at least 2");
    end
    if (IMG_W % WS != 0) begin : g_bad_w
        $fatal(1, "pool_window_buffer: IMG_W must be a multiple of WINDOW_SIZE");
    end
    if (IMG_H % WS != 0) begin : g_bad_h
        $fatal(1, "pool_window_buffer: IMG_H must be a multiple of WINDOW_SIZE");
    end

    // The column/row position is kept split as (window index, offset inside window):
    // col = r_win_x*WS + r_sub_col, row = r_win_y*WS + r_sub_row. This makes the
    // completion test and the window indices free of any divide/modulo.
    logic [SUB_W-1:0] r_sub_col;
    logic [SUB_W-1:0] r_sub_row;
    logic [WX_W-1:0]  r_win_x;
    logic [WY_W-1:0]  r_win_y;

    logic             r_out_valid;
    logic [WIN_W-1:0] r_out_window;
    logic [WX_W-1:0]  r_out_x;
    logic [WY_W-1:0]  r_out_y;
    logic             r_out_last;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_sub_col_last;
    logic             w_sub_row_last;
    logic             w_win_x_last;
    logic             w_win_y_last;
    logic             w_complete;
    logic             w_frame_last;
    logic [COL_W-1:0] w_wr_col;
    logic [WIN_W-1:0] w_band;
    logic [WIN_W-1:0] w_window;

    assign w_in_ready     = !clear && (!r_out_valid || out_ready);
    assign w_accept       = in_valid && w_in_ready;

    assign w_sub_col_last = (r_sub_col == SUB_LAST);
    assign w_sub_row_last = (r_sub_row == SUB_LAST);
    assign w_win_x_last   = (r_win_x == WX_LAST);
    assign w_win_y_last   = (r_win_y == WY_LAST);

    assign w_complete     = w_accept && w_sub_col_last && w_sub_row_last;
    assign w_frame_last   = w_win_x_last && w_win_y_last;

    assign w_wr_col       = COL_W'(r_win_x) * COL_W'(WS) + COL_W'(r_sub_col);

    pool_line_buf #(
        .WS    (WS),
        .DW    (DATA_WIDTH),
        .IMG_W (IMG_W)
    ) u_line_buf (
        .i_clk       (clk),
        .i_wr_en     (w_accept),
        .i_wr_row    (r_sub_row),
        .i_wr_col    (w_wr_col),
        .i_wr_dat    (in_data),
        .i_rd_band   (r_win_x),
        .o_rd_window (w_band)
    );

    // Storage slot row r already holds image row (row-WS+1+r) because the completing
    // pixel sits in slot row WS-1. That pixel itself is still on in_data, so the
    // bottom-right element bypasses the buffer.
    always_comb begin
        w_window = w_band;
        w_window[WIN_W-1 -: DATA_WIDTH] = in_data;
    end

    // Raster position counters; advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_col <= '0;
            r_sub_row <= '0;
            r_win_x   <= '0;
            r_win_y   <= '0;
        end else if (clear) begin
            r_sub_col <= '0;
            r_sub_row <= '0;
            r_win_x   <= '0;
            r_win_y   <= '0;
        end else if (w_accept) begin
            if (!w_sub_col_last) begin
                r_sub_col <= r_sub_col + SUB_W'(1);
            end else begin
                r_sub_col <= '0;
                if (!w_win_x_last) begin
                    r_win_x <= r_win_x + WX_W'(1);
                end else begin
                    // End of an image row.
                    r_win_x <= '0;
                    if (!w_sub_row_last) begin
                        r_sub_row <= r_sub_row + SUB_W'(1);
                    end else begin
                        r_sub_row <= '0;
                        r_win_y   <= w_win_y_last ? '0 : r_win_y + WY_W'(1);
                    end
                end
            end
        end
    end

    // Single-entry output register. A completion can only happen when the entry is
    // empty or being drained this cycle, so loading never overwrites a live window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_last   <= 1'b0;
        end else if (clear) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_last   <= 1'b0;
        end else if (w_complete) begin
            r_out_valid  <= 1'b1;
            r_out_window <= w_window;
            r_out_x      <= r_win_x;
            r_out_y      <= r_win_y;
            r_out_last   <= w_frame_last;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_window = r_out_window;
    assign out_win_x  = r_out_x;
    assign out_win_y  = r_out_y;
    assign out_last   = r_out_last;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a WS=2 4x4 instance and a WS=4 16x16 instance share
// the stimulus; sel routes pixels to one of them. Expected windows are queued on
// pixel acceptance and compared by an independent monitor on each output handshake.
module tb_pool_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, in_valid, out_ready, sel, rnd_on;
    logic [31:0] in_data;

    logic         rdy2, vld2, last2;
    logic [127:0] win2;
    logic [0:0]   wx2, wy2;
    logic         rdy4, vld4, last4;
    logic [511:0] win4;
    logic [1:0]   wx4, wy4;

    pool_window_buffer #(.WINDOW_SIZE(2), .DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid & ~sel), .in_ready(rdy2), .in_data(in_data),
        .out_valid(vld2), .out_ready(out_ready | sel), .out_window(win2),
        .out_win_x(wx2), .out_win_y(wy2), .out_last(last2)
    );

    pool_window_buffer #(.WINDOW_SIZE(4), .DATA_WIDTH(32), .IMG_W(16), .IMG_H(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid & sel), .in_ready(rdy4), .in_data(in_data),
        .out_valid(vld4), .out_ready(out_ready | ~sel), .out_window(win4),
        .out_win_x(wx4), .out_win_y(wy4), .out_last(last4)
    );

    logic         cur_rdy, cur_vld, cur_last;
    logic [511:0] cur_win;
    logic [1:0]   cur_x, cur_y;

    always_comb begin
        if (sel) begin
            cur_rdy = rdy4; cur_vld = vld4; cur_last = last4;
            cur_win = win4; cur_x = wx4; cur_y = wy4;
        end else begin
            cur_rdy = rdy2; cur_vld = vld2; cur_last = last2;
            cur_win = {384'b0, win2}; cur_x = {1'b0, wx2}; cur_y = {1'b0, wy2};
        end
    end

    typedef struct {
        logic [511:0] win;
        int           x;
        int           y;
        bit           last;
        int           lat;   // cycle count at which the window must first show, -1 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_cnt = 0;
    int   pop_cnt  = 0;

    // Hand-computed windows of a 4x4 ramp with 2x2 windows, raster window order.
    int tbl2 [4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Window k of a ramp frame starting at base.
    function automatic logic [511:0] win_of(input int ws, input int w, input int base, input int k);
        logic [511:0] v;
        int wx, wy;
        v  = '0;
        wx = k % (w / ws);
        wy = k / (w / ws);
        for (int r = 0; r < ws; r++)
            for (int c = 0; c < ws; c++)
                if (ws == 2) v[(r*ws+c)*32 +: 32] = 32'(tbl2[k][r*ws+c] + base);
                else         v[(r*ws+c)*32 +: 32] = 32'(base + (wy*ws+r)*w + wx*ws + c);
        return v;
    endfunction

    // Monitor: every handshake consumes one expected window.
    always @(negedge clk) begin
        if (rst_n && cur_vld && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_window: got x=%0d y=%0d, required no window", cur_x, cur_y);
            end else begin
                mon_e = exp_q.pop_front();
                pop_cnt++;
                check("window", cur_win, mon_e.win);
                check("win_x", 512'(cur_x), 512'(mon_e.x));
                check("win_y", 512'(cur_y), 512'(mon_e.y));
                check("last", 512'(cur_last), 512'(mon_e.last));
                if (mon_e.lat >= 0) check("latency_cycle", 512'(cyc), 512'(mon_e.lat));
                if (cur_last) last_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input bit rnd, output bit ok);
        if (rnd) while ($urandom_range(0, 1) == 0) tick();
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = cur_rdy;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: pixel %0d not accepted, required accepted", d);
        end
    endtask

    task automatic send_frame(input int ws, input int w, input int h, input int base,
                              input int first, input int npix, input bit chk_lat, input bit rnd);
        bit   ok;
        int   x, y;
        exp_t e;
        for (int i = first; i < npix; i++) begin
            x = i % w;
            y = i / w;
            send(32'(base + i), rnd, ok);
            if (ok && (x % ws == ws - 1) && (y % ws == ws - 1)) begin
                e.win  = win_of(ws, w, base, (y / ws) * (w / ws) + x / ws);
                e.x    = x / ws;
                e.y    = y / ws;
                e.last = (x == w - 1) && (y == h - 1);
                e.lat  = chk_lat ? cyc : -1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) tick();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d windows outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    int l0, p0;

    initial begin
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; sel = 1'b0; rnd_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 512'(vld2), 512'(0));
        check("rst_in_ready", 512'(rdy2), 512'(1));
        check("rst_window", 512'(win2), 512'(0));
        check("rst_last", 512'(last2), 512'(0));
        check("rst4_out_valid", 512'(vld4), 512'(0));
        check("rst4_in_ready", 512'(rdy4), 512'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: basic 4x4 frame, one window after pixels 5, 7, 13, 15
        send_frame(2, 4, 4, 0, 0, 16, 1'b1, 1'b0);
        drain();

        // 2: backpressure after the first window
        send_frame(2, 4, 4, 0, 0, 6, 1'b0, 1'b0);
        out_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", 512'(vld2), 512'(1));
            check("bp_window", cur_win, win_of(2, 4, 0, 0));
            check("bp_in_ready", 512'(rdy2), 512'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_frame(2, 4, 4, 0, 6, 16, 1'b1, 1'b0);
        drain();

        // 3: two back-to-back 16x16 frames with 4x4 windows
        sel = 1'b1;
        l0 = last_cnt; p0 = pop_cnt;
        send_frame(4, 16, 16, 0, 0, 256, 1'b1, 1'b0);
        send_frame(4, 16, 16, 0, 0, 256, 1'b1, 1'b0);
        drain();
        check("s3_window_count", 512'(pop_cnt - p0), 512'(32));
        check("s3_last_count", 512'(last_cnt - l0), 512'(2));
        sel = 1'b0;
        tick();

        // 4: asynchronous reset mid-row, then a fresh frame
        send_frame(2, 4, 4, 0, 0, 7, 1'b1, 1'b0);
        drain();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 512'(vld2), 512'(0));
        check("arst_in_ready", 512'(rdy2), 512'(1));
        check("arst_window", 512'(win2), 512'(0));
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(2, 4, 4, 0, 0, 16, 1'b1, 1'b0);
        drain();

        // 5: clear with a pixel offered, then clear dropping a held window
        send_frame(2, 4, 4, 0, 0, 9, 1'b1, 1'b0);
        in_data = 32'd9; in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 512'(rdy2), 512'(0));
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        send_frame(2, 4, 4, 0, 0, 6, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        check("clr_held_valid", 512'(vld2), 512'(1));
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("clr_out_valid", 512'(vld2), 512'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_frame(2, 4, 4, 0, 0, 16, 1'b1, 1'b0);
        drain();

        // 6: random valid/ready over 20 frames with distinct pixel values
        l0 = last_cnt; p0 = pop_cnt;
        rnd_on = 1'b1;
        for (int f = 0; f < 20; f++) send_frame(2, 4, 4, f * 16, 0, 16, 1'b0, 1'b1);
        rnd_on = 1'b0;
        out_ready = 1'b1;
        drain();
        check("s6_window_count", 512'(pop_cnt - p0), 512'(80));
        check("s6_last_count", 512'(last_cnt - l0), 512'(20));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
